// File: rtl/mole_controller.sv
// mole_controller: pops one mole at a time on an 8-hole LED array with LFSR hole choice,
// times gap/up/flash windows in 1 ms ticks by difficulty, and turns rising switch edges
// into one-cycle hit/miss/wrong pulses; all outputs registered (one cycle after the cause).
// Ports: in  clk, rst_n (synchronous, active-low), enable, difficulty_level[1:0], hit_sw[7:0]
//        out mole_led[7:0], mole_idx[2:0], mole_active, hit_pulse, miss_pulse, wrong_pulse
module mole_controller #(
  parameter int MS_DIV   = 100000,
  parameter int UP_MS_E  = 1500,
  parameter int UP_MS_M  = 1000,
  parameter int UP_MS_H  = 600,
  parameter int GAP_MS_E = 500,
  parameter int GAP_MS_M = 350,
  parameter int GAP_MS_H = 200,
  parameter int FLASH_MS = 150
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [1:0] difficulty_level,
  input  logic [7:0] hit_sw,
  output logic [7:0] mole_led,
  output logic [2:0] mole_idx,
  output logic       mole_active,
  output logic       hit_pulse,
  output logic       miss_pulse,
  output logic       wrong_pulse
);

  localparam int PW = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam int TW = 16;

  typedef enum logic [1:0] {IDLE, GAP, UP, FLASH} state_t;

  state_t          state, state_nx;
  logic [15:0]     lfsr;
  logic [7:0]      prev_sw;
  logic [PW-1:0]   presc;
  logic [TW-1:0]   ms_timer;

  logic [7:0]      sw_edge;
  logic            tick, expire;
  logic [2:0]      cand, pick;
  logic [TW-1:0]   gap_load, up_load, load_val;
  logic            load;
  logic [7:0]      led_nx;
  logic [2:0]      idx_nx;
  logic            act_nx, hit_nx, miss_nx, wrong_nx;

  assign sw_edge = hit_sw & ~prev_sw;
  assign tick    = (presc == PW'(MS_DIV - 1));
  assign expire  = tick && (ms_timer == '0);

  // Bump the candidate by one when it matches the current hole so a hole never repeats.
  assign cand = lfsr[2:0];
  assign pick = (cand == mole_idx) ? cand + 3'd1 : cand;

  // Durations are stored as D-1 because the expiring tick is the one seen at zero.
  always_comb begin
    gap_load = TW'(GAP_MS_H - 1);
    up_load  = TW'(UP_MS_H - 1);
    case (difficulty_level)
      2'd0: begin gap_load = TW'(GAP_MS_E - 1); up_load = TW'(UP_MS_E - 1); end
      2'd1: begin gap_load = TW'(GAP_MS_M - 1); up_load = TW'(UP_MS_M - 1); end
      default: ;
    endcase
  end

  always_comb begin
    state_nx = state;
    led_nx   = mole_led;
    idx_nx   = mole_idx;
    act_nx   = mole_active;
    hit_nx   = 1'b0;
    miss_nx  = 1'b0;
    wrong_nx = 1'b0;
    load     = 1'b0;
    load_val = '0;
    if (!enable) begin
      // Abort from any state; the current mole is dropped without a verdict.
      state_nx = IDLE;
      led_nx   = '0;
      act_nx   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state_nx = GAP;
          load     = 1'b1;
          load_val = gap_load;
        end
        GAP: begin
          if (expire) begin
            state_nx = UP;
            idx_nx   = pick;
            led_nx   = 8'b1 << pick;
            act_nx   = 1'b1;
            load     = 1'b1;
            load_val = up_load;
          end
        end
        UP: begin
          // Hit outranks expiry and any simultaneous wrong-hole edge.
          if (sw_edge[mole_idx]) begin
            hit_nx   = 1'b1;
            led_nx   = '0;
            act_nx   = 1'b0;
            state_nx = FLASH;
            load     = 1'b1;
            load_val = TW'(FLASH_MS - 1);
          end else if (expire) begin
            miss_nx  = 1'b1;
            led_nx   = '0;
            act_nx   = 1'b0;
            state_nx = GAP;
            load     = 1'b1;
            load_val = gap_load;
          end else if (|sw_edge) begin
            wrong_nx = 1'b1;
          end
        end
        FLASH: begin
          if (expire) begin
            state_nx = GAP;
            load     = 1'b1;
            load_val = gap_load;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      lfsr        <= 16'hACE1;
      prev_sw     <= '0;
      presc       <= '0;
      ms_timer    <= '0;
      mole_led    <= '0;
      mole_idx    <= '0;
      mole_active <= 1'b0;
      hit_pulse   <= 1'b0;
      miss_pulse  <= 1'b0;
      wrong_pulse <= 1'b0;
    end else begin
      state   <= state_nx;
      // Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1, right-shifting.
      lfsr    <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      prev_sw <= hit_sw;
      // Every expiry reloads, so the timer never decrements past zero.
      if (load) begin
        presc    <= '0;
        ms_timer <= load_val;
      end else if (state_nx == IDLE) begin
        presc    <= '0;
        ms_timer <= '0;
      end else if (tick) begin
        presc    <= '0;
        ms_timer <= ms_timer - TW'(1);
      end else begin
        presc    <= presc + PW'(1);
      end
      mole_led    <= led_nx;
      mole_idx    <= idx_nx;
      mole_active <= act_nx;
      hit_pulse   <= hit_nx;
      miss_pulse  <= miss_nx;
      wrong_pulse <= wrong_nx;
    end
  end

endmodule

// File: tb/tb_mole_controller.sv
// tb_mole_controller: directed and randomised stimulus for mole_controller with scaled timing.
// A cycle-count model (phase + cycles remaining) predicts every output each cycle;
// literal checks pin reset values, window lengths, pulse latency and LFSR reseed.
module tb_mole_controller;

  localparam int MSD      = 2;
  localparam int UP_E     = 5;
  localparam int UP_M     = 4;
  localparam int UP_H     = 3;
  localparam int GAP_E    = 3;
  localparam int GAP_M    = 2;
  localparam int GAP_H    = 2;
  localparam int FLASH    = 4;

  localparam int PH_IDLE  = 0;
  localparam int PH_GAP   = 1;
  localparam int PH_UP    = 2;
  localparam int PH_FLASH = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] difficulty_level = 2'd0;
  logic [7:0] hit_sw = 8'h00;
  logic [7:0] mole_led;
  logic [2:0] mole_idx;
  logic       mole_active, hit_pulse, miss_pulse, wrong_pulse;

  int total = 0;
  int bad   = 0;

  mole_controller #(
    .MS_DIV(MSD), .UP_MS_E(UP_E), .UP_MS_M(UP_M), .UP_MS_H(UP_H),
    .GAP_MS_E(GAP_E), .GAP_MS_M(GAP_M), .GAP_MS_H(GAP_H), .FLASH_MS(FLASH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .difficulty_level(difficulty_level),
    .hit_sw(hit_sw), .mole_led(mole_led), .mole_idx(mole_idx), .mole_active(mole_active),
    .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .wrong_pulse(wrong_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int gap_cyc(input logic [1:0] d);
    return (d == 2'd0) ? GAP_E * MSD : (d == 2'd1) ? GAP_M * MSD : GAP_H * MSD;
  endfunction

  function automatic int up_cyc(input logic [1:0] d);
    return (d == 2'd0) ? UP_E * MSD : (d == 2'd1) ? UP_M * MSD : UP_H * MSD;
  endfunction

  // Behavioural model: phase plus remaining cycles in that phase.
  int          m_ph = PH_IDLE;
  int          m_rem = 0;
  logic [15:0] m_lfsr = 16'hACE1;
  logic [7:0]  m_prev = 8'h00;
  logic [7:0]  m_led = 8'h00;
  logic [2:0]  m_idx = 3'd0;
  logic        m_act = 1'b0, m_hit = 1'b0, m_miss = 1'b0, m_wrong = 1'b0;
  logic [2:0]  last_idx = 3'd0;
  logic        last_act = 1'b0;

  always @(posedge clk) begin
    logic [7:0] e;
    int cand;
    int fb;
    e = hit_sw & ~m_prev;
    m_hit = 1'b0; m_miss = 1'b0; m_wrong = 1'b0;
    if (!rst_n) begin
      m_ph = PH_IDLE; m_rem = 0; m_lfsr = 16'hACE1; m_prev = 8'h00;
      m_led = 8'h00; m_idx = 3'd0; m_act = 1'b0;
    end else begin
      if (!enable) begin
        m_ph = PH_IDLE; m_led = 8'h00; m_act = 1'b0;
      end else begin
        case (m_ph)
          PH_IDLE: begin m_ph = PH_GAP; m_rem = gap_cyc(difficulty_level); end
          PH_GAP: begin
            if (m_rem == 1) begin
              cand = int'(m_lfsr) % 8;
              if (cand == int'(m_idx)) cand = (cand + 1) % 8;
              m_idx = 3'(cand);
              m_led = 8'(1 << cand);
              m_act = 1'b1;
              m_ph  = PH_UP;
              m_rem = up_cyc(difficulty_level);
            end else m_rem--;
          end
          PH_UP: begin
            if (e[m_idx]) begin
              m_hit = 1'b1; m_led = 8'h00; m_act = 1'b0;
              m_ph = PH_FLASH; m_rem = FLASH * MSD;
            end else if (m_rem == 1) begin
              m_miss = 1'b1; m_led = 8'h00; m_act = 1'b0;
              m_ph = PH_GAP; m_rem = gap_cyc(difficulty_level);
            end else begin
              m_rem--;
              if (e != 8'h00) m_wrong = 1'b1;
            end
          end
          default: begin
            if (m_rem == 1) begin m_ph = PH_GAP; m_rem = gap_cyc(difficulty_level); end
            else m_rem--;
          end
        endcase
      end
      fb = (int'(m_lfsr) ^ (int'(m_lfsr) >> 2) ^ (int'(m_lfsr) >> 3) ^ (int'(m_lfsr) >> 5)) & 1;
      m_lfsr = 16'((int'(m_lfsr) >> 1) | (fb << 15));
      m_prev = hit_sw;
    end
    #1;
    chk("outputs", {17'd0, mole_led, mole_idx, mole_active, hit_pulse, miss_pulse, wrong_pulse},
        {17'd0, m_led, m_idx, m_act, m_hit, m_miss, m_wrong});
    chk("led_onehot_or_zero", 32'($countones(mole_led) <= 1), 32'd1);
    chk("pulses_exclusive", 32'(int'(hit_pulse) + int'(miss_pulse) + int'(wrong_pulse) <= 1), 32'd1);
    if (mole_active && !last_act) chk("no_repeat_hole", 32'(mole_idx != last_idx), 32'd1);
    last_act = mole_active;
    last_idx = mole_idx;
  end

  task automatic wait_on();
    int n = 0;
    while (mole_led == 8'h00 && n < 300) begin @(negedge clk); n++; end
    chk("wait_on_timeout", 32'(mole_led != 8'h00), 32'd1);
  endtask

  task automatic wait_off();
    int n = 0;
    while (mole_led != 8'h00 && n < 300) begin @(negedge clk); n++; end
    chk("wait_off_timeout", 32'(mole_led == 8'h00), 32'd1);
  endtask

  // Returns at the negedge just after GAP entry.
  task automatic start_from_reset();
    rst_n = 1'b0; enable = 1'b0; hit_sw = 8'h00; difficulty_level = 2'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int z, o, hits, pulses;
    logic [2:0] first_hole, saved_idx;
    logic [7:0] saved_led;

    // Reset values
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {21'd0, mole_led, mole_idx, mole_active, hit_pulse, miss_pulse, wrong_pulse}, 32'd0);

    // 1: gap 6 cycles dark, up 10 cycles, then miss
    start_from_reset();
    z = 0;
    while (mole_led == 8'h00 && z < 100) begin z++; @(negedge clk); end
    chk("gap_len_easy", z, 6);
    first_hole = mole_idx;
    o = 0;
    while (mole_led != 8'h00 && o < 100) begin o++; @(negedge clk); end
    chk("up_len_easy", o, 10);
    chk("miss_after_expiry", miss_pulse, 1);
    @(negedge clk);
    chk("miss_one_cycle", miss_pulse, 0);

    // 2: hit -> next cycle pulse and dark; flash 8 + gap 6 dark cycles
    wait_on();
    hit_sw = mole_led;
    @(negedge clk);
    chk("hit_latency", hit_pulse, 1);
    chk("hit_led_dark", mole_led, 0);
    z = 0;
    while (mole_led == 8'h00 && z < 100) begin
      z++;
      if (z == 2) hit_sw = 8'h00;
      @(negedge clk);
    end
    chk("flash_plus_gap_len", z, 14);

    // 3: wrong hole, LED and up window unchanged; then hit+wrong same cycle
    wait_on();
    saved_led = mole_led;
    o = 0;
    while (mole_led != 8'h00 && o < 100) begin
      o++;
      if (o == 1) hit_sw = 8'(1 << ((int'(mole_idx) + 3) % 8));
      if (o == 2) begin
        chk("wrong_pulse", wrong_pulse, 1);
        chk("wrong_led_same", mole_led, saved_led);
        hit_sw = 8'h00;
      end
      @(negedge clk);
    end
    chk("up_len_after_wrong", o, 10);
    chk("miss_after_wrong", miss_pulse, 1);
    wait_on();
    hit_sw = mole_led | 8'(1 << ((int'(mole_idx) + 3) % 8));
    @(negedge clk);
    chk("hit_and_wrong_hit", hit_pulse, 1);
    chk("hit_and_wrong_nowrong", wrong_pulse, 0);
    hit_sw = 8'h00;

    // 4: held switch gives one hit; switches held across enable rise give nothing
    wait_on();
    hit_sw = mole_led;
    hits = 0;
    repeat (40) begin @(negedge clk); hits += int'(hit_pulse); end
    chk("held_single_hit", hits, 1);
    enable = 1'b0;
    hit_sw = 8'hFF;
    repeat (3) @(negedge clk);
    enable = 1'b1;
    pulses = 0;
    repeat (25) begin @(negedge clk); pulses += int'(hit_pulse | wrong_pulse); end
    chk("held_across_enable", pulses, 0);
    hit_sw = 8'h00;

    // 5: 200 moles with random hit/wrong/none and random difficulty
    for (int m = 0; m < 200; m++) begin
      wait_on();
      difficulty_level = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 2))
        1: begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          hit_sw = mole_led;
          @(negedge clk);
          hit_sw = 8'h00;
        end
        2: begin
          hit_sw = 8'(1 << ((int'(mole_idx) + 1 + int'($urandom_range(0, 6))) % 8));
          @(negedge clk);
          hit_sw = 8'h00;
        end
        default: ;
      endcase
      wait_off();
    end
    difficulty_level = 2'd2;
    wait_on();
    o = 0;
    while (mole_led != 8'h00 && o < 100) begin o++; @(negedge clk); end
    chk("up_len_hard", o, 6);

    // 6: enable drop mid-UP, then reset mid-GAP and reseed check
    difficulty_level = 2'd0;
    wait_on();
    repeat (2) @(negedge clk);
    saved_idx = mole_idx;
    enable = 1'b0;
    @(negedge clk);
    chk("abort_led", mole_led, 0);
    chk("abort_active", mole_active, 0);
    chk("abort_pulses", {hit_pulse, miss_pulse, wrong_pulse}, 0);
    chk("abort_idx_hold", mole_idx, saved_idx);
    enable = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midgap_reset_outputs", {21'd0, mole_led, mole_idx, mole_active, hit_pulse, miss_pulse, wrong_pulse}, 32'd0);
    start_from_reset();
    wait_on();
    chk("reseed_first_hole", mole_idx, first_hole);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
